// File: rtl/uart_tx_multi_if.sv
// Handshake and serial-line bundle for uart_tx_multi: per-channel word offer,
// holding-register ready, serial outputs and busy flags.
interface uart_tx_multi_if #(
  parameter int NCH       = 3,
  parameter int DATA_BITS = 8
);
  logic [NCH-1:0]           in_valid;
  logic [NCH-1:0]           in_ready;
  logic [NCH*DATA_BITS-1:0] in_data;
  logic [NCH-1:0]           tx;
  logic [NCH-1:0]           busy;

  modport master (output in_valid, output in_data, input in_ready, input tx, input busy);
  modport slave  (input in_valid, input in_data, output in_ready, output tx, output busy);
endinterface

// File: rtl/uart_tx_multi.sv
// Multi-channel UART transmitter: NCH double-buffered channels serialising LSB-first
// on a shared baud tick. Macro UART_TX_PARITY_EN compiles in one parity bit per frame.
module uart_tx_multi #(
  parameter int NCH        = 3,
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_multi_if.slave  bus
);

  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  // One counter serves both the data-bit and stop-bit phases.
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    return (^word) ^ 1'(PARITY_ODD);
  endfunction
`else
  // PARITY_ODD has no effect without the parity bit.
  if (PARITY_ODD < 0) begin : g_parity_unused
  end
`endif

  logic [BAUD_W-1:0] baud_cnt_r;
  logic              tick_s;

  assign tick_s = (baud_cnt_r == BAUD_LAST);

  // Shared free-running baud counter; all channels step on the same tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= '0;
    end else if (tick_s) begin
      baud_cnt_r <= '0;
    end else begin
      baud_cnt_r <= baud_cnt_r + BAUD_ONE;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t                state_r, state_nxt_s;
    logic [DATA_BITS-1:0]  shift_r, shift_nxt_s;
    logic [DATA_BITS-1:0]  hold_r, hold_nxt_s;
    logic                  hold_valid_r, hold_valid_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic                  tx_r, tx_nxt_s;
    logic                  busy_r;
    logic                  ready_r;
    logic                  accept_s;
    logic                  load_s;
    logic [DATA_BITS-1:0]  word_s;
`ifdef UART_TX_PARITY_EN
    logic                  parity_r, parity_nxt_s;
`endif

    assign word_s   = bus.in_data[i*DATA_BITS +: DATA_BITS];
    assign accept_s = bus.in_valid[i] & ready_r;

    // Next-state, shifter and holding-register logic for one channel.
    always_comb begin
      state_nxt_s      = state_r;
      shift_nxt_s      = shift_r;
      hold_nxt_s       = hold_r;
      hold_valid_nxt_s = hold_valid_r;
      cnt_nxt_s        = cnt_r;
      tx_nxt_s         = tx_r;
      load_s           = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_nxt_s     = parity_r;
`endif
      if (accept_s) begin
        hold_nxt_s       = word_s;
        hold_valid_nxt_s = 1'b1;
      end else begin
        hold_nxt_s       = hold_r;
      end
      if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            if (hold_valid_r) begin
              load_s = 1'b1;
            end else begin
              tx_nxt_s = 1'b1;
            end
          end
          ST_START: begin
            state_nxt_s = ST_DATA;
            tx_nxt_s    = shift_r[0];
            shift_nxt_s = shift_r >> 1;
            cnt_nxt_s   = '0;
          end
          ST_DATA: begin
            if (cnt_r == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_nxt_s = ST_PARITY;
              tx_nxt_s    = parity_r;
`else
              state_nxt_s = ST_STOP;
              tx_nxt_s    = 1'b1;
              cnt_nxt_s   = '0;
`endif
            end else begin
              tx_nxt_s    = shift_r[0];
              shift_nxt_s = shift_r >> 1;
              cnt_nxt_s   = cnt_r + CNT_ONE;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            state_nxt_s = ST_STOP;
            tx_nxt_s    = 1'b1;
            cnt_nxt_s   = '0;
          end
`endif
          ST_STOP: begin
            if (cnt_r == STOP_LAST) begin
              if (hold_valid_r) begin
                load_s = 1'b1;
              end else begin
                state_nxt_s = ST_IDLE;
                tx_nxt_s    = 1'b1;
              end
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_nxt_s = ST_IDLE;
            tx_nxt_s    = 1'b1;
          end
        endcase
        // Hold cannot be empty-and-accepting while draining, so this never collides with accept_s.
        if (load_s) begin
          state_nxt_s      = ST_START;
          tx_nxt_s         = 1'b0;
          shift_nxt_s      = hold_r;
          hold_valid_nxt_s = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_nxt_s     = parity_of(hold_r);
`endif
        end else begin
          load_s = 1'b0;
        end
      end else begin
        load_s = 1'b0;
      end
    end

    // Channel state registers; tx, busy and in_ready are all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r      <= ST_IDLE;
        shift_r      <= '0;
        hold_r       <= '0;
        hold_valid_r <= 1'b0;
        cnt_r        <= '0;
        tx_r         <= 1'b1;
        busy_r       <= 1'b0;
        ready_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_r     <= 1'b0;
`endif
      end else begin
        state_r      <= state_nxt_s;
        shift_r      <= shift_nxt_s;
        hold_r       <= hold_nxt_s;
        hold_valid_r <= hold_valid_nxt_s;
        cnt_r        <= cnt_nxt_s;
        tx_r         <= tx_nxt_s;
        busy_r       <= (state_nxt_s != ST_IDLE);
        ready_r      <= !hold_valid_nxt_s;
`ifdef UART_TX_PARITY_EN
        parity_r     <= parity_nxt_s;
`endif
      end
    end

    assign bus.tx[i]       = tx_r;
    assign bus.busy[i]     = busy_r;
    assign bus.in_ready[i] = ready_r;
  end

endmodule

// File: doc/uart_tx_multi.md
# uart_tx_multi

Parametrised multi-channel UART transmitter: the next-generation replacement for the fixed three-pin `uart_tx` in the TinyTapeout top. Each of `NCH` channels accepts words over a valid/ready handshake, double-buffers them, and serialises them LSB-first on its own `tx` pin at a shared baud rate set by `CLK_DIV`. Back-to-back words go out with no idle gap. Optional parity is compiled in by macro.

## Interface
- `NCH`, 3: number of independent channels (≥1).
- `DATA_BITS`, 8: data bits per frame (5..9).
- `CLK_DIV`, 16: clock cycles per bit (≥2).
- `STOP_BITS`, 1: stop bits per frame (1 or 2).
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Only meaningful with `UART_TX_PARITY_EN`.

- `clk`  in  1  sole clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  NCH  per-channel word-offered strobe.
- `in_ready`  out  NCH  per-channel holding register empty.
- `in_data`  in  NCH*DATA_BITS  channel i uses bits [i*DATA_BITS +: DATA_BITS].
- `tx`  out  NCH  serial outputs; idle high.
- `busy`  out  NCH  channel i is shifting a frame (state ≠ IDLE).

## Operation
- Reset values: `tx`=all 1, `in_ready`=all 1, `busy`=all 0. Baud counter=0, all holding registers empty, all channels IDLE.
- Baud generator: one shared counter 0..CLK_DIV-1, free-running from reset. `tick` is asserted when the counter equals CLK_DIV-1; the counter then wraps to 0. All channels share `tick`, so their bit boundaries are aligned.
- Handshake: `in_ready[i]` = !hold_valid[i], driven from a register. A word is accepted on a rising edge where `in_valid[i]` && `in_ready[i]`. It is captured into the holding register. `in_data` is ignored when not accepted.
- Per-channel FSM, advancing only on `tick`:
  - IDLE: `tx`=1. If hold_valid, go to START. Move hold to the shift register and clear hold_valid.
  - START: `tx`=0 for one bit, then DATA.
  - DATA: `tx`=shift[0], shifting right each tick. After DATA_BITS bits go to PARITY if enabled, otherwise STOP.
  - PARITY: `tx`=XOR of the data bits, XOR PARITY_ODD. One bit, then STOP.
  - STOP: `tx`=1 for STOP_BITS bits. Then, if hold_valid, go to START (reloading as in IDLE); otherwise go to IDLE.
- `tx` is driven from a register and updates on the edge at which `tick` is sampled high.
- Simultaneous events:
  - An accept and a hold drain cannot coincide: `in_ready` is 0 while hold is full.
  - An accept in the cycle after a drain is legal.
- `in_valid` may drop without acceptance; there is no obligation to hold it.
- Channels are fully independent apart from the shared `tick`.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronously). The frame is truncated and the held word is discarded.

## Timing
- Each bit lasts exactly CLK_DIV cycles.
- Frame length is (1 + DATA_BITS + P + STOP_BITS)·CLK_DIV cycles, where P=1 with the macro and 0 without.
- Accept-to-start-bit latency from IDLE: 1..CLK_DIV cycles, depending on baud counter phase.
- `in_ready` rises in the cycle after the hold word moves to the shifter. A single channel therefore sustains one word per frame time with no gap between frames.
- `busy` rises with the start bit and falls in the cycle after the last stop bit ends, when no word is held.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state and logic are compiled in, and one parity bit is inserted between data and stop.
  - Undefined: no parity state, logic or bit; `PARITY_ODD` is unused; frames are 8N1-style.

## Test plan
- Reset, then idle 100 cycles -> `tx`=3'b111, `in_ready`=3'b111, `busy`=0 throughout.
- NCH=3, DATA_BITS=8, CLK_DIV=4, no parity; send 0x55 on ch0 -> `tx[0]` bits 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40-cycle frame); `tx[1]` and `tx[2]` stay 1.
- Ch1: offer 0xA5 then 0x3C back-to-back, holding `in_valid` high -> second start bit immediately follows the first stop bit with no idle cycles; `in_ready` low while hold is full; `busy` high for 80 cycles.
- All three channels load 0x01, 0x80, 0xFF in the same cycle -> start bits and bit edges on all three coincide; each data pattern is correct LSB-first.
- With `UART_TX_PARITY_EN`, PARITY_ODD=0, send 0x07 -> parity bit 1, 11-bit frame (44 cycles). With PARITY_ODD=1 -> parity bit 0.
- Assert `rst_n`=0 during data bit 3 of ch2 with a word held -> `tx[2]`=1 immediately. After release, no residual frame is sent and `in_ready[2]`=1.
